// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers, single-cycle flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + PW'(1);
      if (pop_i)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset; entries are only visible through count
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    !(push_i && !pop_i && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests, in-order
// response tracking with redirect flush, and a prefetch queue feeding decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    imem_req_valid_o,
  input  logic                    imem_req_ready_i,
  output logic [XLEN-1:0]         imem_req_addr_o,
  input  logic                    imem_rsp_valid_i,
  input  logic [INSTR_W-1:0]      imem_rsp_data_i,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_pc_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [INSTR_W-1:0]      id_instr_o,
  output logic [XLEN-1:0]         id_pc_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [$clog2(DEPTH):0]  occupancy_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned EW = XLEN + INSTR_W;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [IW-1:0]   r_inflight;
  logic [IW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic [EW-1:0]   w_head;
  logic [31:0]     w_credit;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic            w_id_valid;
  logic            w_unused_pc_lsb;

  assign w_redirect_pc   = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // Every issued request owns a queue slot, so responses can never overflow the queue
  assign w_credit    = 32'(w_count) + 32'(r_inflight);
  assign w_req_valid = rst_i && !redirect_i && (32'(r_inflight) < MAX_OUTSTANDING) &&
                       (w_credit < DEPTH);
  assign w_fire      = w_req_valid && imem_req_ready_i;

  assign w_rsp       = imem_rsp_valid_i && (r_inflight != '0);
  assign w_push      = w_rsp && !redirect_i && (r_discard == '0);
  assign w_id_valid  = (w_count != '0);
  assign w_pop       = w_id_valid && id_ready_i && !redirect_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (redirect_i) begin
      // Everything still outstanding after this edge belongs to the old path
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
      r_inflight <= r_inflight - IW'(w_rsp);
      r_discard  <= r_inflight - IW'(w_rsp);
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      if (w_push) r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
      if (w_rsp && (r_discard != '0)) r_discard <= r_discard - IW'(1);
      r_inflight <= r_inflight + IW'(w_fire) - IW'(w_rsp);
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .clear_i (redirect_i),
    .push_i  (w_push),
    .data_i  ({r_rsp_pc, imem_rsp_data_i}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count)
  );

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_fetch_pc;
  assign pc_o             = r_fetch_pc;
  assign occupancy_o      = w_count;
  assign id_valid_o       = w_id_valid;
  assign id_instr_o       = w_id_valid ? w_head[INSTR_W-1:0] : NOP_INSTR;
  assign id_pc_o          = w_id_valid ? w_head[EW-1:INSTR_W] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a PC scoreboard checked at every head
// transfer, and directed scenarios for stall, hold, redirect, reset and PC wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, imem_req_ready_i, imem_rsp_valid_i, redirect_i, id_ready_i;
  logic [31:0] imem_rsp_data_i, redirect_pc_i;
  logic        imem_req_valid_o, id_valid_o;
  logic [31:0] imem_req_addr_o, id_instr_o, id_pc_o, pc_o;
  logic [2:0]  occupancy_o;

  logic        wr_rst, wr_req_valid, wr_rsp_valid, wr_id_valid;
  logic [31:0] wr_rsp_data, wr_req_addr, wr_id_instr, wr_id_pc, wr_pc;
  logic [2:0]  wr_occ;

  int n_total = 0;
  int n_bad   = 0;

  logic        mem_en;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_pc = 32'h0;
  int          m_count = 0;
  int          m_disc = 0;
  logic        mon_exp_req;
  int          mon_ncnt;
  logic [31:0] mon_exp_pc;
  logic        wf_fire = 1'b0;
  logic [31:0] wf_addr = 32'h0;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .pc_o(pc_o), .occupancy_o(occupancy_o)
  );

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
               .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .rst_i(wr_rst),
    .imem_req_valid_o(wr_req_valid), .imem_req_ready_i(1'b1),
    .imem_req_addr_o(wr_req_addr),
    .imem_rsp_valid_i(wr_rsp_valid), .imem_rsp_data_i(wr_rsp_data),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .id_valid_o(wr_id_valid), .id_ready_i(1'b1), .id_instr_o(wr_id_instr),
    .id_pc_o(wr_id_pc), .pc_o(wr_pc), .occupancy_o(wr_occ)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // In-order memory: answers the oldest pending request each cycle while enabled
  always @(posedge clk) begin
    #2;
    if (mem_en && pend_q.size() != 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = instr_of(pend_q[0]);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    wf_fire = wr_rst && wr_req_valid;
    wf_addr = wr_req_addr;
  end

  always @(posedge clk) begin
    #2;
    wr_rsp_valid = wf_fire;
    wr_rsp_data  = instr_of(wf_addr);
  end

  // Reference model and scoreboard; evaluates the effect of the coming rising edge
  always @(negedge clk) begin
    mon_exp_req = rst_i && !redirect_i && (pend_q.size() < MAXO) &&
                  (m_count + pend_q.size() < DEPTH);
    n_total++;
    if (imem_req_valid_o !== mon_exp_req) begin
      n_bad++;
      $display("FAIL req_valid t=%0t got=%b exp=%b", $time, imem_req_valid_o, mon_exp_req);
    end
    n_total++;
    if (occupancy_o !== 3'(m_count)) begin
      n_bad++;
      $display("FAIL occupancy t=%0t got=%0d exp=%0d", $time, occupancy_o, m_count);
    end
    n_total++;
    if (m_count == 0) begin
      if (id_valid_o !== 1'b0 || id_instr_o !== NOP_INSTR || id_pc_o !== 32'h0) begin
        n_bad++;
        $display("FAIL empty_head t=%0t got=%b/%h/%h exp=0/%h/0", $time, id_valid_o,
                 id_instr_o, id_pc_o, NOP_INSTR);
      end
    end else if (id_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL head_valid t=%0t got=%b exp=1", $time, id_valid_o);
    end

    if (!rst_i) begin
      pend_q.delete();
      exp_q.delete();
      m_pc    = 32'h0;
      m_count = 0;
      m_disc  = 0;
    end else if (redirect_i) begin
      if (imem_rsp_valid_i) void'(pend_q.pop_front());
      m_disc  = pend_q.size();
      m_count = 0;
      exp_q.delete();
      m_pc    = redirect_pc_i & ~32'd3;
    end else begin
      mon_ncnt = m_count;
      if (m_count != 0 && id_ready_i) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_empty t=%0t got_pc=%h exp=none", $time, id_pc_o);
        end else begin
          mon_exp_pc = exp_q.pop_front();
          if (id_pc_o !== mon_exp_pc || id_instr_o !== instr_of(mon_exp_pc)) begin
            n_bad++;
            $display("FAIL sb_head t=%0t got=%h/%h exp=%h/%h", $time, id_pc_o, id_instr_o,
                     mon_exp_pc, instr_of(mon_exp_pc));
          end
        end
        mon_ncnt--;
      end
      if (imem_rsp_valid_i) begin
        void'(pend_q.pop_front());
        if (m_disc > 0) m_disc--;
        else mon_ncnt++;
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        n_total++;
        if (imem_req_addr_o !== m_pc) begin
          n_bad++;
          $display("FAIL req_addr t=%0t got=%h exp=%h", $time, imem_req_addr_o, m_pc);
        end
        exp_q.push_back(m_pc);
        pend_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_count = mon_ncnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_total++;
    if (pc_o !== 32'h0 || imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b0 ||
        id_instr_o !== NOP_INSTR || id_pc_o !== 32'h0 || occupancy_o !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%h/%b/%b/%h/%h/%0d exp=0/0/0/%h/0/0", pc_o,
               imem_req_valid_o, id_valid_o, id_instr_o, id_pc_o, occupancy_o, NOP_INSTR);
    end
    rst_i = 1'b1;
    #1;
    n_total++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL first_req got=%b/%h exp=1/0", imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_stream();
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 + 4 * i)) begin
        n_bad++;
        $display("FAIL stream i=%0d got=%b/%h exp=1/%h", i, id_valid_o, id_pc_o, 4 + 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    tick();
    id_ready_i = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    n_total++;
    if (occupancy_o !== 3'd4 || imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_full got=%0d/%b/%b exp=4/0/1", occupancy_o, imem_req_valid_o,
               id_valid_o);
    end
    tick();
    id_ready_i = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_req_hold();
    logic [31:0] hold;
    tick();
    imem_req_ready_i = 1'b0;
    hold = m_pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== hold || pc_o !== hold) begin
        n_bad++;
        $display("FAIL req_hold i=%0d got=%b/%h/%h exp=1/%h", i, imem_req_valid_o,
                 imem_req_addr_o, pc_o, hold);
      end
    end
    tick();
    imem_req_ready_i = 1'b1;
    tick();
    n_total++;
    if (pc_o !== hold + 32'd4) begin
      n_bad++;
      $display("FAIL req_advance got=%h exp=%h", pc_o, hold + 32'd4);
    end
    repeat (6) tick();
  endtask

  task automatic wait_head(input logic [31:0] exp_pc, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (!ok || id_pc_o !== exp_pc || id_instr_o !== instr_of(exp_pc)) begin
      n_bad++;
      $display("FAIL %s got=%b/%h/%h exp=1/%h/%h", name, ok, id_pc_o, id_instr_o, exp_pc,
               instr_of(exp_pc));
    end
  endtask

  task automatic test_redirect();
    tick();
    mem_en = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_total++;
    if (imem_req_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
      n_bad++;
      $display("FAIL cap_two got=%b/%0d exp=0/0", imem_req_valid_o, occupancy_o);
    end
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    n_total++;
    if (imem_req_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL redirect_noreq got=%b exp=0", imem_req_valid_o);
    end
    tick();
    redirect_i = 1'b0;
    mem_en     = 1'b1;
    n_total++;
    if (pc_o !== 32'h100 || imem_req_addr_o !== 32'h100) begin
      n_bad++;
      $display("FAIL redirect_pc got=%h/%h exp=100", pc_o, imem_req_addr_o);
    end
    wait_head(32'h100, "redirect_head");
  endtask

  task automatic test_redirect_rsp();
    repeat (4) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    n_total++;
    if (id_valid_o !== 1'b1 || imem_rsp_valid_i !== 1'b1) begin
      n_bad++;
      $display("FAIL redirect_overlap got=%b/%b exp=1/1", id_valid_o, imem_rsp_valid_i);
    end
    tick();
    redirect_i = 1'b0;
    n_total++;
    if (occupancy_o !== 3'd0 || pc_o !== 32'h200) begin
      n_bad++;
      $display("FAIL redirect_rsp_flush got=%0d/%h exp=0/200", occupancy_o, pc_o);
    end
    wait_head(32'h200, "redirect_rsp_head");
  endtask

  task automatic test_back_to_back();
    repeat (3) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    tick();
    redirect_pc_i = 32'h0000_0406;
    tick();
    redirect_i = 1'b0;
    wait_head(32'h404, "b2b_head");
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    repeat (4) tick();
    rst_i = 1'b0;
    tick();
    n_total++;
    if (pc_o !== 32'h0 || imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b0 ||
        id_instr_o !== NOP_INSTR || id_pc_o !== 32'h0 || occupancy_o !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_reset got=%h/%b/%b/%h/%h/%0d exp=0/0/0/%h/0/0", pc_o,
               imem_req_valid_o, id_valid_o, id_instr_o, id_pc_o, occupancy_o, NOP_INSTR);
    end
    rst_i = 1'b1;
    wait_head(32'h0, "post_reset_head");
    repeat (6) tick();
  endtask

  task automatic test_wrap();
    logic [31:0] wexp[3];
    logic ok;
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    n_total++;
    if (wr_pc !== 32'hFFFF_FFF8 || wr_req_valid !== 1'b0 || wr_occ !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_reset got=%h/%b/%0d exp=fffffff8/0/0", wr_pc, wr_req_valid, wr_occ);
    end
    tick();
    wr_rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_id_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (!ok || wr_id_valid !== 1'b1 || wr_id_pc !== wexp[i] ||
          wr_id_instr !== instr_of(wexp[i])) begin
        n_bad++;
        $display("FAIL wrap i=%0d got=%b/%h/%h exp=1/%h/%h", i, wr_id_valid, wr_id_pc,
                 wr_id_instr, wexp[i], instr_of(wexp[i]));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i            = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'h0;
    id_ready_i       = 1'b1;
    mem_en           = 1'b1;
    wr_rst           = 1'b0;
    wr_rsp_valid     = 1'b0;
    wr_rsp_data      = 32'h0;

    test_reset();
    test_stream();
    test_stall();
    test_req_hold();
    test_redirect();
    test_redirect_rsp();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
